// File: rtl/apb_pkg.sv
// Shared APB definitions: default bus widths, slave memory depth and the
// transfer-phase enum used by both the requester and slave-side checkers.
`timescale 1ns/1ps
package apb_pkg;

  localparam int unsigned APB_ADDR_WIDTH = 32;
  localparam int unsigned APB_DATA_WIDTH = 8;
  localparam int unsigned MEM_DEPTH      = 256;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

endpackage

// File: rtl/apb_master_bridge.sv
// APB requester: turns a valid/ready command into SETUP/ACCESS transfers and
// reports each completion (data, slave error, wait-state timeout) on a one-cycle strobe.
`timescale 1ns/1ps
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = APB_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH     = APB_DATA_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_slverr,
  output logic                  rsp_timeout,
  output logic                  busy,
  output logic                  PSELx,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR,
  output apb_state_e            state_dbg
);

  // Command handshake: a command transfers on the rising edge where
  // cmd_valid && cmd_ready; cmd_* are don't-care while cmd_ready is low.
  // The response side has no backpressure: rsp_valid is a single-cycle pulse.

  localparam int unsigned CNT_W_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned CNT_W     = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  apb_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_inc;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_slverr_q, rsp_slverr_d;
  logic                  rsp_timeout_q, rsp_timeout_d;
  logic                  timeout_hit;
  logic                  cmd_accept;

  assign cnt_inc = cnt_q + CNT_W'(1);

  // PREADY high on the limit cycle wins over the abort.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (state_q == ACCESS) && !PREADY &&
                       (cnt_inc == CNT_LIMIT);

  assign cmd_ready  = (state_q == IDLE) || ((state_q == ACCESS) && PREADY && !timeout_hit);
  assign cmd_accept = cmd_valid && cmd_ready;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_slverr_d  = rsp_slverr_q;
    rsp_timeout_d = rsp_timeout_q;

    unique case (state_q)
      IDLE: begin
        if (cmd_accept) begin
          state_d  = SETUP;
          cnt_d    = '0;
          pwrite_d = cmd_write;
          paddr_d  = cmd_addr;
          pwdata_d = cmd_wdata;
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        if (PREADY) begin
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = pwrite_q ? '0 : PRDATA;
          rsp_slverr_d  = PSLVERR;
          rsp_timeout_d = 1'b0;
          if (cmd_accept) begin
            state_d  = SETUP;
            cnt_d    = '0;
            pwrite_d = cmd_write;
            paddr_d  = cmd_addr;
            pwdata_d = cmd_wdata;
          end else begin
            state_d = IDLE;
          end
        end else if (timeout_hit) begin
          state_d       = IDLE;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_slverr_d  = 1'b1;
          rsp_timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // APB strobes are registered copies of the next phase.
    psel_d    = (state_d != IDLE);
    penable_d = (state_d == ACCESS);
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_slverr_q  <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_slverr_q  <= rsp_slverr_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign PSELx       = psel_q;
  assign PENABLE     = penable_q;
  assign PWRITE      = pwrite_q;
  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_slverr  = rsp_slverr_q;
  assign rsp_timeout = rsp_timeout_q;
  assign busy        = (state_q != IDLE);
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: behavioural APB slave with programmable waits and
// hang mode, reference memory and expected-response queue, directed plus random traffic.
`timescale 1ns/1ps
module tb_apb_master_bridge;
  import apb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 8;
  localparam int TO = 16;
  localparam int EW = DW + 2;

  // ---------------- clock / reset ----------------
  logic PCLK = 1'b0;
  logic PRESETn = 1'b0;
  always #5 PCLK = ~PCLK;

  int cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  logic          cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          cmd_ready, rsp_valid, rsp_slverr, rsp_timeout, busy;
  logic [DW-1:0] rsp_rdata;
  logic          PSELx, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA, PRDATA;
  apb_state_e    state_dbg;

  apb_master_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_slverr(rsp_slverr),
    .rsp_timeout(rsp_timeout), .busy(busy),
    .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .state_dbg(state_dbg)
  );

  // ---------------- behavioural slave ----------------
  logic [DW-1:0] slv_mem [MEM_DEPTH];
  int  slv_wcnt = 0, slv_target = 0, slv_wait_max = 0;
  bit  slv_hang = 1'b0;
  logic in_range;

  assign in_range = (PADDR < AW'(MEM_DEPTH));
  assign PREADY   = PSELx && PENABLE && !slv_hang && (slv_wcnt >= slv_target);
  assign PSLVERR  = PSELx && PENABLE && !in_range;
  assign PRDATA   = in_range ? slv_mem[PADDR[7:0]] : '0;

  always @(posedge PCLK) begin
    if (PSELx && !PENABLE) begin
      slv_wcnt   <= 0;
      slv_target <= $urandom_range(0, slv_wait_max);
    end else if (PSELx && PENABLE && !PREADY) begin
      slv_wcnt <= slv_wcnt + 1;
    end
    if (PSELx && PENABLE && PREADY && PWRITE && in_range)
      slv_mem[PADDR[7:0]] <= PWDATA;
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  logic [DW-1:0] ref_mem [MEM_DEPTH];
  logic [EW-1:0] exp_q[$];   // {timeout, slverr, rdata}
  int            rsp_cyc_q[$];

  task automatic model_push(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit ok;
    ok = (a < AW'(MEM_DEPTH));
    if (slv_hang) begin
      exp_q.push_back({1'b1, 1'b1, {DW{1'b0}}});
    end else if (w) begin
      if (ok) ref_mem[a[7:0]] = d;
      exp_q.push_back({1'b0, !ok, {DW{1'b0}}});
    end else begin
      exp_q.push_back({1'b0, !ok, ok ? ref_mem[a[7:0]] : {DW{1'b0}}});
    end
  endtask

  always @(negedge PCLK) begin
    logic [EW-1:0] e;
    if (rsp_valid) begin
      rsp_cyc_q.push_back(cyc);
      check_eq("rsp_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_eq("rsp_rdata", 64'(rsp_rdata), 64'(e[DW-1:0]));
        check_eq("rsp_slverr", 64'(rsp_slverr), 64'(e[DW]));
        check_eq("rsp_timeout", 64'(rsp_timeout), 64'(e[DW+1]));
      end
    end
  end

  bit b2b_mon = 1'b0;
  int psel_drop = 0;
  always @(negedge PCLK) if (b2b_mon && !PSELx) psel_drop <= psel_drop + 1;

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic send(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d, input bit keep);
    int n;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    n = 0;
    while (!cmd_ready && n < 100) begin
      @(negedge PCLK);
      n++;
    end
    if (n >= 100) begin
      check_eq("accept_timeout", 64'(cmd_ready), 64'd1);
    end else begin
      model_push(w, a, d);
    end
    @(negedge PCLK);
    if (!keep) cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 300) begin
      @(negedge PCLK);
      n++;
    end
    check_eq("drain_done", 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n, pen_cnt;
    bit w, keep;
    logic [AW-1:0] a;
    for (int i = 0; i < MEM_DEPTH; i++) begin
      slv_mem[i] = '0;
      ref_mem[i] = '0;
    end

    // reset values
    repeat (3) @(negedge PCLK);
    check_eq("rst_psel", 64'(PSELx), 64'd0);
    check_eq("rst_penable", 64'(PENABLE), 64'd0);
    check_eq("rst_apb_regs", 64'({PWRITE, PADDR, PWDATA}), 64'd0);
    check_eq("rst_rsp", 64'({rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout}), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_state", 64'(state_dbg), 64'(IDLE));
    PRESETn = 1'b1;
    @(negedge PCLK);

    // zero-wait write: SETUP N+1, ACCESS N+2, rsp N+3
    send(1'b1, 32'd10, 8'hAA, 1'b0);
    check_eq("w1_setup_psel", 64'(PSELx), 64'd1);
    check_eq("w1_setup_pen", 64'(PENABLE), 64'd0);
    @(negedge PCLK);
    check_eq("w1_access_pen", 64'({PSELx, PENABLE}), 64'b11);
    check_eq("w1_access_norsp", 64'(rsp_valid), 64'd0);
    @(negedge PCLK);
    check_eq("w1_rsp_valid", 64'(rsp_valid), 64'd1);
    check_eq("w1_rsp_psel", 64'(PSELx), 64'd0);
    check_eq("w1_slave_mem", 64'(slv_mem[10]), 64'hAA);
    @(negedge PCLK);
    check_eq("w1_rsp_pulse", 64'(rsp_valid), 64'd0);

    // writes then readback, out-of-range read
    send(1'b1, 32'd11, 8'h55, 1'b0);
    send(1'b1, 32'd12, 8'hF0, 1'b0);
    send(1'b0, 32'd10, 8'h00, 1'b0);
    send(1'b0, 32'd11, 8'h00, 1'b0);
    send(1'b0, 32'd12, 8'h00, 1'b0);
    send(1'b0, 32'(MEM_DEPTH + 5), 8'h00, 1'b0);
    drain();

    // back-to-back: 4 commands with cmd_valid held
    rsp_cyc_q.delete();
    psel_drop = 0;
    send(1'b1, 32'd3, 8'h31, 1'b1);
    b2b_mon = 1'b1;
    send(1'b0, 32'd3, 8'h00, 1'b1);
    send(1'b1, 32'd4, 8'h42, 1'b1);
    send(1'b0, 32'd4, 8'h00, 1'b0);
    @(negedge PCLK);
    b2b_mon = 1'b0;
    drain();
    check_eq("b2b_psel_drop", 64'(psel_drop), 64'd0);
    check_eq("b2b_rsp_count", 64'(rsp_cyc_q.size()), 64'd4);
    if (rsp_cyc_q.size() == 4)
      for (int i = 1; i < 4; i++)
        check_eq("b2b_rsp_gap", 64'(rsp_cyc_q[i] - rsp_cyc_q[i-1]), 64'd2);

    // timeout with a hung slave
    slv_hang = 1'b1;
    send(1'b0, 32'd5, 8'h00, 1'b0);
    n = 1;
    pen_cnt = 0;
    while (!rsp_valid && n < 100) begin
      @(negedge PCLK);
      n++;
      if (PENABLE) pen_cnt++;
    end
    check_eq("to_latency", 64'(n), 64'(TO + 2));
    check_eq("to_wait_cycles", 64'(pen_cnt), 64'(TO));
    check_eq("to_psel_low", 64'(PSELx), 64'd0);
    slv_hang = 1'b0;
    send(1'b0, 32'd11, 8'h00, 1'b0);
    drain();

    // reset during an ACCESS wait state
    slv_hang = 1'b1;
    send(1'b1, 32'd20, 8'h33, 1'b0);
    repeat (3) @(negedge PCLK);
    check_eq("mid_pen_before", 64'(PENABLE), 64'd1);
    PRESETn = 1'b0;
    #1;
    check_eq("mid_rst_psel", 64'({PSELx, PENABLE}), 64'd0);
    check_eq("mid_rst_busy", 64'(busy), 64'd0);
    exp_q.delete();
    rsp_cyc_q.delete();
    slv_hang = 1'b0;
    repeat (2) @(negedge PCLK);
    PRESETn = 1'b1;
    repeat (3) @(negedge PCLK);
    check_eq("mid_no_rsp", 64'(rsp_cyc_q.size()), 64'd0);
    send(1'b1, 32'd20, 8'h33, 1'b0);
    send(1'b0, 32'd20, 8'h00, 1'b0);
    drain();
    check_eq("mid_slave_mem", 64'(slv_mem[20]), 64'h33);

    // randomized traffic with wait states
    slv_wait_max = 3;
    for (int i = 0; i < 60; i++) begin
      w    = 1'($urandom_range(0, 1));
      a    = ($urandom_range(0, 9) == 0) ? 32'(MEM_DEPTH + $urandom_range(0, 40))
                                         : 32'($urandom_range(0, 15));
      keep = 1'($urandom_range(0, 1));
      send(w, a, 8'($urandom), keep);
      if (!keep) repeat ($urandom_range(0, 2)) @(negedge PCLK);
    end
    cmd_valid = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

endmodule
